wd_reg_cycle: RTL and testbench

- Register-access sequencer for the WD33C93 SCSI controller.
- Sits directly downstream of the SDMAC address decoder and consumes its WDREGREQ strobe (CPU access at offset >= 0x40).
- Converts each decoded CPU cycle into a timed WD33C93 chip-select / read / write strobe sequence, then returns DTACK_ to the CPU.
- Handles CPU cycle termination and abort.

---
 rtl/wd_reg_cycle_if.sv | 44 ++++
 rtl/wd_reg_cycle.sv | 146 ++++++++++++++
 tb/tb_wd_reg_cycle.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wd_reg_cycle_if.sv
// WD33C93 register-access bus: CPU/decoder request side and WD strobe side.
interface wd_reg_cycle_if;
  logic WDREGREQ;
  logic AS_;
  logic R_W;
  logic ADDR1;
  logic SCSI_CS_;
  logic IOR_;
  logic IOW_;
  logic WD_A0;
  logic RDLATCH;
  logic DTACK_;
  logic BUSY;

  // Decoder/CPU side: drives the request, observes the WD strobes and DTACK_.
  modport master (
    output WDREGREQ,
    output AS_,
    output R_W,
    output ADDR1,
    input  SCSI_CS_,
    input  IOR_,
    input  IOW_,
    input  WD_A0,
    input  RDLATCH,
    input  DTACK_,
    input  BUSY
  );

  // Sequencer side.
  modport slave (
    input  WDREGREQ,
    input  AS_,
    input  R_W,
    input  ADDR1,
    output SCSI_CS_,
    output IOR_,
    output IOW_,
    output WD_A0,
    output RDLATCH,
    output DTACK_,
    output BUSY
  );
endinterface

// File: rtl/wd_reg_cycle.sv
// WD33C93 register-access sequencer: turns a decoded CPU cycle into a timed
// chip-select / read / write strobe sequence and returns DTACK_ to the CPU.
module wd_reg_cycle #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic           SCLK,
  input logic           RST_,
  wd_reg_cycle_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StAck} state_e;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

  logic       req_meta_q, req_s_q;
  logic       as_meta_q, as_s_q;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       abort_q, abort_d;
  logic       a0_q, a0_d;

  logic       cs_n_q, cs_n_d;
  logic       ior_n_q, ior_n_d;
  logic       iow_n_q, iow_n_d;
  logic       rdlatch_q, rdlatch_d;
  logic       dtack_n_q, dtack_n_d;
  logic       busy_q, busy_d;

  // Two-flop synchronisers for the asynchronous request and address strobe.
  always_ff @(posedge SCLK or negedge RST_) begin
    if (!RST_) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      as_meta_q  <= 1'b1;
      as_s_q     <= 1'b1;
    end else begin
      req_meta_q <= bus.WDREGREQ;
      req_s_q    <= req_meta_q;
      as_meta_q  <= bus.AS_;
      as_s_q     <= as_meta_q;
    end
  end

  // State, counter, latched cycle attributes and registered outputs.
  always_ff @(posedge SCLK or negedge RST_) begin
    if (!RST_) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      abort_q   <= 1'b0;
      a0_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
      rdlatch_q <= 1'b0;
      dtack_n_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      abort_q   <= abort_d;
      a0_q      <= a0_d;
      cs_n_q    <= cs_n_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
      rdlatch_q <= rdlatch_d;
      dtack_n_q <= dtack_n_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: phase sequencing, counter reloads and abort tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rw_d    = rw_q;
    abort_d = abort_q;
    a0_d    = a0_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (req_s_q && !as_s_q) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          rw_d    = bus.R_W;
          a0_d    = bus.ADDR1;
          abort_d = 1'b0;
        end
      end
      StSetup: begin
        // Abort before the strobe starts: drop the access with no WD strobe.
        if (as_s_q) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end
      end
      StStrobe: begin
        // Strobe is never truncated; only remember the abort.
        if (as_s_q) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end
      end
      StHold: begin
        if (as_s_q) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = (abort_q || as_s_q) ? StIdle : StAck;
        end
      end
      StAck: begin
        if (as_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, decoded from the next state so outputs move with the state.
  always_comb begin
    cs_n_d    = !(state_d inside {StSetup, StStrobe, StHold});
    ior_n_d   = !((state_d == StStrobe) && rw_d);
    iow_n_d   = !((state_d == StStrobe) && !rw_d);
    rdlatch_d = (state_d == StStrobe) && rw_d && (cnt_d == 4'd0);
    dtack_n_d = (state_d != StAck);
    busy_d    = (state_d != StIdle);
  end

  assign bus.SCSI_CS_ = cs_n_q;
  assign bus.IOR_     = ior_n_q;
  assign bus.IOW_     = iow_n_q;
  assign bus.WD_A0    = a0_q;
  assign bus.RDLATCH  = rdlatch_q;
  assign bus.DTACK_   = dtack_n_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_wd_reg_cycle.sv
// Directed bench for wd_reg_cycle: three instances (default timing, long setup,
// long strobe/hold) share one stimulus; each scenario checks one instance
// edge by edge against hand-derived windows.
module tb_wd_reg_cycle;

  logic SCLK = 1'b0;
  logic RST_ = 1'b0;
  logic wdregreq = 1'b0;
  logic as_n = 1'b1;
  logic r_w = 1'b0;
  logic addr1 = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int edge_n = 0;
  int sel = 0;

  // One access: edge windows (inclusive) in which each signal is active.
  typedef struct {
    int cs_from;
    int str_from;
    int str_to;
    int cs_to;
    int dt_from;
    int dt_to;
    int busy_to;
    bit rw;
    bit a0;
  } acc_t;

  acc_t accs[2];
  int   nacc = 1;
  bit   a0_init = 1'b0;

  // Observed vector: {SCSI_CS_, IOR_, IOW_, RDLATCH, DTACK_, BUSY, WD_A0}
  localparam logic [6:0] RstVec = 7'b1110100;

  always #5 SCLK = ~SCLK;

  wd_reg_cycle_if bus_a ();
  wd_reg_cycle_if bus_b ();
  wd_reg_cycle_if bus_c ();

  assign bus_a.WDREGREQ = wdregreq;
  assign bus_a.AS_      = as_n;
  assign bus_a.R_W      = r_w;
  assign bus_a.ADDR1    = addr1;
  assign bus_b.WDREGREQ = wdregreq;
  assign bus_b.AS_      = as_n;
  assign bus_b.R_W      = r_w;
  assign bus_b.ADDR1    = addr1;
  assign bus_c.WDREGREQ = wdregreq;
  assign bus_c.AS_      = as_n;
  assign bus_c.R_W      = r_w;
  assign bus_c.ADDR1    = addr1;

  wd_reg_cycle dut_a (
    .SCLK (SCLK),
    .RST_ (RST_),
    .bus  (bus_a)
  );

  wd_reg_cycle #(
    .SETUP_CYC (4)
  ) dut_b (
    .SCLK (SCLK),
    .RST_ (RST_),
    .bus  (bus_b)
  );

  wd_reg_cycle #(
    .STROBE_CYC (15),
    .HOLD_CYC   (15)
  ) dut_c (
    .SCLK (SCLK),
    .RST_ (RST_),
    .bus  (bus_c)
  );

  function automatic logic [6:0] obs_vec();
    logic [6:0] v;
    case (sel)
      1:       v = {bus_b.SCSI_CS_, bus_b.IOR_, bus_b.IOW_, bus_b.RDLATCH,
                    bus_b.DTACK_, bus_b.BUSY, bus_b.WD_A0};
      2:       v = {bus_c.SCSI_CS_, bus_c.IOR_, bus_c.IOW_, bus_c.RDLATCH,
                    bus_c.DTACK_, bus_c.BUSY, bus_c.WD_A0};
      default: v = {bus_a.SCSI_CS_, bus_a.IOR_, bus_a.IOW_, bus_a.RDLATCH,
                    bus_a.DTACK_, bus_a.BUSY, bus_a.WD_A0};
    endcase
    return v;
  endfunction

  function automatic logic [6:0] exp_at(input int e);
    logic cs, ior, iow, rdl, dt, busy, a0;
    cs = 1'b1; ior = 1'b1; iow = 1'b1; rdl = 1'b0; dt = 1'b1; busy = 1'b0; a0 = a0_init;
    for (int i = 0; i < nacc; i++) begin
      if (e >= accs[i].cs_from && e <= accs[i].cs_to) cs = 1'b0;
      if (e >= accs[i].str_from && e <= accs[i].str_to) begin
        if (accs[i].rw) ior = 1'b0;
        else            iow = 1'b0;
        if (accs[i].rw && e == accs[i].str_to) rdl = 1'b1;
      end
      if (e >= accs[i].dt_from && e <= accs[i].dt_to) dt = 1'b0;
      if (e >= accs[i].cs_from && e <= accs[i].busy_to) busy = 1'b1;
      if (e >= accs[i].cs_from) a0 = accs[i].a0;
    end
    return {cs, ior, iow, rdl, dt, busy, a0};
  endfunction

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cs ior iow rdl dtack busy a0)", tag, got, exp);
  endtask

  task automatic step(input string name);
    @(posedge SCLK);
    #1;
    edge_n++;
    check_eq($sformatf("%s e=%0d", name, edge_n), obs_vec(), exp_at(edge_n));
  endtask

  task automatic cpu_start(input logic rw, input logic a);
    wdregreq = 1'b1;
    as_n     = 1'b0;
    r_w      = rw;
    addr1    = a;
  endtask

  task automatic cpu_end();
    as_n     = 1'b1;
    wdregreq = 1'b0;
  endtask

  task automatic edge0();
    @(posedge SCLK);
    #1;
    edge_n = 0;
  endtask

  task automatic do_reset(input string name);
    RST_ = 1'b0;
    cpu_end();
    repeat (2) @(posedge SCLK);
    #1;
    check_eq({name, " reset"}, obs_vec(), RstVec);
    RST_ = 1'b1;
    repeat (3) @(posedge SCLK);
  endtask

  initial begin
    // Read of the data register (offset 0x42).
    sel = 0; nacc = 1; a0_init = 1'b0;
    do_reset("read");
    accs[0] = '{3, 4, 6, 7, 8, 12, 12, 1'b1, 1'b1};
    edge0();
    cpu_start(1'b1, 1'b1);
    repeat (14) begin
      step("read");
      if (edge_n == 10) cpu_end();
    end

    // Write of the address register (offset 0x40), straight after the read.
    a0_init = 1'b1;
    accs[0] = '{3, 4, 6, 7, 8, 12, 12, 1'b0, 1'b0};
    edge0();
    cpu_start(1'b0, 1'b0);
    repeat (14) begin
      step("write");
      if (edge_n == 10) cpu_end();
    end

    // Abort during SETUP with a 4-cycle setup: no strobe, no DTACK_.
    sel = 1; a0_init = 1'b0;
    do_reset("abort_setup");
    accs[0] = '{3, 0, -1, 5, 0, -1, 5, 1'b1, 1'b1};
    edge0();
    cpu_start(1'b1, 1'b1);
    repeat (9) begin
      step("abort_setup");
      if (edge_n == 3) cpu_end();
    end

    // Abort during STROBE: strobe and hold complete, no DTACK_.
    sel = 0; a0_init = 1'b0;
    do_reset("abort_strobe");
    accs[0] = '{3, 4, 6, 7, 0, -1, 7, 1'b1, 1'b1};
    edge0();
    cpu_start(1'b1, 1'b1);
    repeat (11) begin
      step("abort_strobe");
      if (edge_n == 4) cpu_end();
    end

    // Reset in the middle of a write strobe, then a fresh write.
    do_reset("rst_mid");
    accs[0] = '{3, 4, 6, 7, 8, 12, 12, 1'b0, 1'b1};
    edge0();
    cpu_start(1'b0, 1'b1);
    repeat (5) step("rst_mid");
    RST_ = 1'b0;
    cpu_end();
    #1;
    check_eq("rst_mid async", obs_vec(), RstVec);
    @(posedge SCLK);
    #1;
    check_eq("rst_mid held", obs_vec(), RstVec);
    RST_ = 1'b1;
    repeat (2) @(posedge SCLK);
    a0_init = 1'b0;
    edge0();
    cpu_start(1'b0, 1'b1);
    repeat (14) begin
      step("after_rst");
      if (edge_n == 10) cpu_end();
    end

    // Back-to-back reads with 15-cycle strobe and hold.
    sel = 2; nacc = 2; a0_init = 1'b0;
    do_reset("b2b");
    accs[0] = '{3, 4, 18, 33, 34, 38, 38, 1'b1, 1'b1};
    accs[1] = '{41, 42, 56, 71, 72, 76, 76, 1'b1, 1'b0};
    edge0();
    cpu_start(1'b1, 1'b1);
    repeat (79) begin
      step("b2b");
      if (edge_n == 36) cpu_end();
      if (edge_n == 38) cpu_start(1'b1, 1'b0);
      if (edge_n == 74) cpu_end();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
